// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned FUNC_W   = 8;
    localparam int unsigned ALU_OP_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_STORE  = 4'b0001;
    localparam logic [OP_W-1:0] OP_JUMP   = 4'b0010;
    localparam logic [OP_W-1:0] OP_BRANCH = 4'b0100;
    localparam logic [OP_W-1:0] OP_RTYPE  = 4'b1000;
    localparam logic [OP_W-1:0] OP_IMM0   = 4'b1100;
    localparam logic [OP_W-1:0] OP_IMM1   = 4'b1101;
    localparam logic [OP_W-1:0] OP_IMM2   = 4'b1110;
    localparam logic [OP_W-1:0] OP_IMM3   = 4'b1111;

    localparam logic [ALU_OP_W-1:0] ALU_ADDR   = 7'b0000010;
    localparam logic [ALU_OP_W-1:0] ALU_BRANCH = 7'b1000111;
    localparam logic [ALU_OP_W-1:0] ALU_IMM0   = 7'b0000010;
    localparam logic [ALU_OP_W-1:0] ALU_IMM1   = 7'b0000100;
    localparam logic [ALU_OP_W-1:0] ALU_IMM2   = 7'b0001000;
    localparam logic [ALU_OP_W-1:0] ALU_IMM3   = 7'b0010000;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    // Opcodes the datapath implements; everything else traps in DECODE.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_JUMP, OP_BRANCH, OP_RTYPE,
            OP_IMM0, OP_IMM1, OP_IMM2, OP_IMM3: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // ALU operation for an opcode; held unchanged through MEM and WB.
    function automatic logic [ALU_OP_W-1:0] alu_op_for(input logic [OP_W-1:0] op,
                                                       input logic [FUNC_W-1:0] func);
        case (op)
            OP_LOAD, OP_STORE: return ALU_ADDR;
            OP_BRANCH:         return ALU_BRANCH;
            OP_RTYPE:          return func[ALU_OP_W-1:0];
            OP_IMM0:           return ALU_IMM0;
            OP_IMM1:           return ALU_IMM1;
            OP_IMM2:           return ALU_IMM2;
            OP_IMM3:           return ALU_IMM3;
            default:           return '0;
        endcase
    endfunction

    // Opcodes whose ALU B operand is the immediate.
    function automatic logic immd_for(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_IMM0, OP_IMM1, OP_IMM2, OP_IMM3: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter shared by the instruction and data handshakes.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;

    // Count waiting cycles; saturate so a disabled timeout never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Fires on the waiting cycle that brings the count up to MEM_TIMEOUT.
    assign expired_c = TIMEOUT_EN && enable && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM with sticky trap.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                immd_sel,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                set_window,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [FUNC_W-1:0]   func_q;
    logic [1:0]          cause_q, cause_d;
    logic                timer_clear;
    logic                timer_en;
    logic                timer_expired;

    // Any state change restarts the wait count, so FETCH and MEM always start from zero.
    assign timer_clear = (state_d != state_q);
    assign timer_en    = ((state_q == ST_FETCH) && !imem_ready) ||
                         ((state_q == ST_MEM)   && !dmem_ready);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .enable    (timer_en),
        .expired_c (timer_expired)
    );

    // State, instruction and trap-cause registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            func_q  <= '0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if ((state_q == ST_FETCH) && imem_ready) begin
                op_q   <= opcode;
                func_q <= func;
            end
        end
    end

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        alu_op     = '0;
        immd_sel   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        set_window = 1'b0;
        trap       = 1'b0;
        trap_cause = TRAP_NONE;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_IMEM;
                end
            end
            ST_DECODE: begin
                if (!op_is_legal(op_q)) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else if (op_q == OP_JUMP) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    state_d  = ST_FETCH;
                end else begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op   = alu_op_for(op_q, func_q);
                immd_sel = immd_for(op_q);
                case (op_q)
                    OP_LOAD, OP_STORE: state_d = ST_MEM;
                    OP_BRANCH: begin
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_BRANCH;
                        end
                        state_d = ST_FETCH;
                    end
                    OP_RTYPE: begin
                        set_window = func_q[7];
                        state_d    = (func_q[7:6] == 2'b00) ? ST_WB : ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                alu_op   = alu_op_for(op_q, func_q);
                immd_sel = immd_for(op_q);
                if (dmem_ready) begin
                    state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DMEM;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LOAD);
                alu_op     = alu_op_for(op_q, func_q);
                immd_sel   = immd_for(op_q);
                state_d    = ST_FETCH;
            end
            ST_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction expected output scripts compared every cycle.
module tb_multicycle_sequencer;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [7:0] func;
    logic       zero, imem_ready, dmem_ready;
    logic       imem_req, ir_load, pc_write;
    logic [1:0] pc_src;
    logic [6:0] alu_op;
    logic       immd_sel, dmem_req, dmem_we, reg_write, mem_to_reg, set_window, trap;
    logic [1:0] trap_cause;

    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .immd_sel(immd_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .set_window(set_window),
        .trap(trap), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic       imem_req;
        logic       ir_load;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [6:0] alu_op;
        logic       immd_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_write;
        logic       mem_to_reg;
        logic       set_window;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct {
        logic       ir;
        logic       dr;
        logic       z;
        logic [3:0] op;
        logic [7:0] fn;
        outs_t      exp;
    } cyc_t;

    cyc_t  q[$];
    outs_t act, exp_o;
    logic  exp_valid;
    int    checks, errors;
    int    dmem_n, we_n, m2r_n, setw_n, regw_n;
    logic [3:0] legal_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};

    assign act = {imem_req, ir_load, pc_write, pc_src, alu_op, immd_sel, dmem_req, dmem_we,
                  reg_write, mem_to_reg, set_window, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle comparison against the scripted expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL outputs @%0t: dut=%06h model=%06h", $time, act, exp_o);
            end
        end
    end

    // Activity counters used for multi-cycle literal checks.
    always @(negedge clk) begin
        if (dmem_req === 1'b1)   dmem_n++;
        if (dmem_we === 1'b1)    we_n++;
        if (mem_to_reg === 1'b1) m2r_n++;
        if (set_window === 1'b1) setw_n++;
        if (reg_write === 1'b1)  regw_n++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: dut=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic logic m_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [6:0] m_alu(input logic [3:0] op, input logic [7:0] fn);
        case (op)
            4'h0, 4'h1: return 7'b0000010;
            4'h4:       return 7'b1000111;
            4'h8:       return fn[6:0];
            4'hC:       return 7'b0000010;
            4'hD:       return 7'b0000100;
            4'hE:       return 7'b0001000;
            4'hF:       return 7'b0010000;
            default:    return 7'b0;
        endcase
    endfunction

    function automatic logic m_immd(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h1) || (op[3:2] == 2'b11);
    endfunction

    // Random don't-care inputs with an all-zero expectation.
    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c.ir  = 1'($urandom_range(0, 1));
        c.dr  = 1'($urandom_range(0, 1));
        c.z   = 1'($urandom_range(0, 1));
        c.op  = 4'($urandom);
        c.fn  = 8'($urandom);
        c.exp = '0;
        return c;
    endfunction

    task automatic plan_trap(input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < 4; i++) begin
            c = rnd_cyc();
            c.exp.trap = 1'b1;
            c.exp.trap_cause = cause;
            q.push_back(c);
        end
    endtask

    // Script one instruction from FETCH up to (not including) the next FETCH.
    task automatic plan_instr(input logic [3:0] op, input logic [7:0] fn,
                              input int iwait, input int dwait, input logic z);
        cyc_t  c;
        outs_t e;
        for (int i = 0; i < iwait && i < TO; i++) begin
            c = rnd_cyc(); c.ir = 1'b0; c.exp.imem_req = 1'b1; q.push_back(c);
        end
        if (iwait >= TO) begin plan_trap(2'b10); return; end
        c = rnd_cyc(); c.ir = 1'b1; c.op = op; c.fn = fn;
        c.exp.imem_req = 1'b1; c.exp.ir_load = 1'b1; q.push_back(c);
        c = rnd_cyc();
        if (!m_legal(op)) begin q.push_back(c); plan_trap(2'b01); return; end
        c.exp.pc_write = 1'b1;
        c.exp.pc_src   = (op == 4'h2) ? 2'b01 : 2'b00;
        q.push_back(c);
        if (op == 4'h2) return;
        e = '0;
        e.alu_op   = m_alu(op, fn);
        e.immd_sel = m_immd(op);
        c = rnd_cyc(); c.z = z; c.exp = e;
        if (op == 4'h4 && z) begin c.exp.pc_write = 1'b1; c.exp.pc_src = 2'b10; end
        if (op == 4'h8) c.exp.set_window = fn[7];
        q.push_back(c);
        if (op == 4'h4 || (op == 4'h8 && fn[7:6] != 2'b00)) return;
        if (op == 4'h0 || op == 4'h1) begin
            for (int i = 0; i < dwait && i < TO; i++) begin
                c = rnd_cyc(); c.dr = 1'b0; c.exp = e;
                c.exp.dmem_req = 1'b1; c.exp.dmem_we = (op == 4'h1); q.push_back(c);
            end
            if (dwait >= TO) begin plan_trap(2'b11); return; end
            c = rnd_cyc(); c.dr = 1'b1; c.exp = e;
            c.exp.dmem_req = 1'b1; c.exp.dmem_we = (op == 4'h1); q.push_back(c);
            if (op == 4'h1) return;
        end
        c = rnd_cyc(); c.exp = e;
        c.exp.reg_write = 1'b1; c.exp.mem_to_reg = (op == 4'h0); q.push_back(c);
    endtask

    task automatic run_queue(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(posedge clk); #1;
            imem_ready = c.ir; dmem_ready = c.dr; zero = c.z; opcode = c.op; func = c.fn;
            exp_o = c.exp; exp_valid = 1'b1;
        end
    endtask

    task automatic run_all();
        run_queue(q.size());
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic hold_and_release();
        q.delete();
        exp_o = '0; exp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        hold_and_release();
    endtask

    initial begin
        int s0, s1, s2;
        checks = 0; errors = 0;
        dmem_n = 0; we_n = 0; m2r_n = 0; setw_n = 0; regw_n = 0;
        rst = 1'b0; opcode = '0; func = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        exp_o = '0; exp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Random legal instruction stream with occasional near-timeout waits.
        for (int k = 0; k < 80; k++) begin
            plan_instr(legal_ops[$urandom_range(0, 8)], 8'($urandom),
                       ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2),
                       ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 2),
                       1'($urandom_range(0, 1)));
            run_all();
        end

        // Asynchronous reset while a data request is outstanding.
        do_reset();
        plan_instr(4'h0, 8'h00, 0, 10, 1'b0);
        run_queue(5);
        #2;
        check("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'(act), 32'd0);
        hold_and_release();
        plan_instr(4'hC, 8'h11, 0, 0, 1'b0);
        run_queue(1);
        sample();
        check("fetch_after_idle", 32'(imem_req), 32'd1);
        run_all();

        // Immediate 1101, zero wait: decode, execute, writeback, four cycles.
        plan_instr(4'hD, 8'h3C, 0, 0, 1'b0);
        run_queue(2); sample();
        check("imm_decode_pc", 32'({pc_write, pc_src}), 32'b100);
        run_queue(1); sample();
        check("imm_exec_alu", 32'({alu_op, immd_sel}), 32'b0000100_1);
        run_queue(1); sample();
        check("imm_wb", 32'({reg_write, mem_to_reg}), 32'b10);
        plan_instr(4'hE, 8'h00, 0, 0, 1'b0);
        run_queue(1); sample();
        check("imm_four_cycles", 32'(imem_req), 32'd1);
        run_all();

        // Load with three data wait cycles.
        s0 = dmem_n; s1 = m2r_n; s2 = we_n;
        plan_instr(4'h0, 8'h00, 0, 3, 1'b0);
        run_all(); sample();
        check("load_dmem_req_cycles", 32'(dmem_n - s0), 32'd4);
        check("load_mem_to_reg", 32'(m2r_n - s1), 32'd1);
        check("load_no_write", 32'(we_n - s2), 32'd0);

        // R-type 0x85: window update, no writeback.
        s0 = setw_n; s1 = regw_n;
        plan_instr(4'h8, 8'h85, 0, 0, 1'b0);
        run_queue(3); sample();
        check("rtype_alu", 32'(alu_op), 32'b0000101);
        run_all();
        plan_instr(4'hF, 8'h00, 0, 0, 1'b0);
        run_queue(1); sample();
        check("rtype_back_to_fetch", 32'(imem_req), 32'd1);
        check("rtype_set_window_once", 32'(setw_n - s0), 32'd1);
        check("rtype_no_reg_write", 32'(regw_n - s1), 32'd0);
        run_all();

        // Branch taken and not taken.
        plan_instr(4'h4, 8'h00, 0, 0, 1'b1);
        run_queue(3); sample();
        check("branch_taken", 32'({pc_write, pc_src}), 32'b110);
        plan_instr(4'h4, 8'h00, 0, 0, 1'b0);
        run_queue(3); sample();
        check("branch_not_taken", 32'({pc_write, pc_src}), 32'b000);
        plan_instr(4'hC, 8'h00, 0, 0, 1'b0);
        run_queue(1); sample();
        check("branch_three_cycles", 32'(imem_req), 32'd1);
        run_all();

        // Illegal opcode trap.
        do_reset();
        plan_instr(4'hA, 8'h00, 0, 0, 1'b0);
        run_all(); sample();
        check("illegal_trap", 32'({trap, trap_cause}), 32'b101);

        // Instruction fetch timeout.
        do_reset();
        plan_instr(4'hD, 8'h00, 16, 0, 1'b0);
        run_all(); sample();
        check("imem_timeout_trap", 32'({trap, trap_cause}), 32'b110);

        // Ready on the last allowed cycle avoids the trap.
        do_reset();
        plan_instr(4'hD, 8'h00, 15, 0, 1'b0);
        run_all(); sample();
        check("imem_ready_at_limit", 32'({trap, reg_write}), 32'b01);

        // Data access timeout.
        do_reset();
        plan_instr(4'h0, 8'h00, 0, 16, 1'b0);
        run_all(); sample();
        check("dmem_timeout_trap", 32'({trap, trap_cause}), 32'b111);

        exp_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
